// File: rtl/lc3_mmio_console.sv
// LC-3 memory-mapped console: KBSR/KBDR keyboard FIFO, DSR/DDR display
// register with valid/ready output, and registered interrupt request.
module lc3_mmio_console #(
    parameter int unsigned KBD_DEPTH = 4,
    parameter logic [2:0]  KBD_PRIO  = 3'd4,
    parameter logic [7:0]  KBD_VEC   = 8'h80,
    parameter logic [2:0]  DSP_PRIO  = 3'd4,
    parameter logic [7:0]  DSP_VEC   = 8'h81
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memory_addr,
    input  logic        MemoryMappedIO_load,
    input  logic [15:0] MemoryMappedIO_out,
    input  logic        mmio_rd,
    output logic [15:0] MemoryMappedIO_in,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        IRQ,
    output logic [2:0]  INTP,
    output logic [7:0]  INTV
);
    localparam int unsigned PTR_W = $clog2(KBD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KBD_DEPTH);
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    if (KBD_DEPTH < 2 || (KBD_DEPTH & (KBD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("KBD_DEPTH must be a power of two and at least 2");
    end

    logic [7:0]       fifo_mem_q [KBD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             kie_q, kie_d;
    logic             die_q, die_d;
    logic             drdy_q, drdy_d;
    logic             dsp_valid_q, dsp_valid_d;
    logic [7:0]       dsp_data_q, dsp_data_d;
    logic             irq_q, irq_d;
    logic [2:0]       intp_q, intp_d;
    logic [7:0]       intv_q, intv_d;

    logic       sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
    logic       fifo_ne, fifo_full;
    logic       push, pop;
    logic       ddr_accept, dsp_hs;
    logic       kreq, dreq;
    logic [7:0] fifo_head;
    logic       unused_wdata;

    assign sel_kbsr = (memory_addr == ADDR_KBSR);
    assign sel_kbdr = (memory_addr == ADDR_KBDR);
    assign sel_dsr  = (memory_addr == ADDR_DSR);
    assign sel_ddr  = (memory_addr == ADDR_DDR);

    assign fifo_ne   = (count_q != '0);
    assign fifo_full = (count_q == CNT_FULL);
    assign fifo_head = fifo_mem_q[rd_ptr_q];

    assign push = kbd_valid & ~fifo_full;
    assign pop  = mmio_rd & sel_kbdr & fifo_ne;

    // A DDR write while drdy=0 (including the handshake cycle) is dropped.
    assign ddr_accept = MemoryMappedIO_load & sel_ddr & drdy_q;
    assign dsp_hs     = dsp_valid_q & dsp_ready;

    assign kreq = fifo_ne & kie_q;
    assign dreq = drdy_q & die_q;

    assign unused_wdata = ^{MemoryMappedIO_out[15], MemoryMappedIO_out[13:8]};

    always_comb begin
        MemoryMappedIO_in = 16'h0000;
        if (sel_kbsr) begin
            MemoryMappedIO_in = {fifo_ne, kie_q, 14'b0};
        end else if (sel_kbdr) begin
            MemoryMappedIO_in = fifo_ne ? {8'h00, fifo_head} : 16'h0000;
        end else if (sel_dsr) begin
            MemoryMappedIO_in = {drdy_q, die_q, 14'b0};
        end else if (sel_ddr) begin
            MemoryMappedIO_in = {8'h00, dsp_data_q};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        kie_d       = kie_q;
        die_d       = die_q;
        drdy_d      = drdy_q;
        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
        if (MemoryMappedIO_load && sel_kbsr) begin
            kie_d = MemoryMappedIO_out[14];
        end
        if (MemoryMappedIO_load && sel_dsr) begin
            die_d = MemoryMappedIO_out[14];
        end
        if (ddr_accept) begin
            dsp_data_d  = MemoryMappedIO_out[7:0];
            dsp_valid_d = 1'b1;
            drdy_d      = 1'b0;
        end else if (dsp_hs) begin
            dsp_valid_d = 1'b0;
            drdy_d      = 1'b1;
        end
    end

    // Keyboard request wins when both devices are asking.
    always_comb begin
        irq_d  = kreq | dreq;
        intp_d = 3'd0;
        intv_d = 8'h00;
        if (kreq) begin
            intp_d = KBD_PRIO;
            intv_d = KBD_VEC;
        end else if (dreq) begin
            intp_d = DSP_PRIO;
            intv_d = DSP_VEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            kie_q       <= 1'b0;
            die_q       <= 1'b0;
            drdy_q      <= 1'b1;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= 8'h00;
            irq_q       <= 1'b0;
            intp_q      <= 3'd0;
            intv_q      <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            kie_q       <= kie_d;
            die_q       <= die_d;
            drdy_q      <= drdy_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
            irq_q       <= irq_d;
            intp_q      <= intp_d;
            intv_q      <= intv_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= kbd_data;
        end
    end

    assign kbd_ready = ~fifo_full;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;
    assign IRQ       = irq_q;
    assign INTP      = intp_q;
    assign INTV      = intv_q;

endmodule

// File: tb/tb_lc3_mmio_console.sv
// Randomized and directed bench for lc3_mmio_console against a queue-based model.
module tb_lc3_mmio_console;
    localparam int unsigned KBD_DEPTH = 4;
    localparam logic [2:0]  KBD_PRIO  = 3'd4;
    localparam logic [7:0]  KBD_VEC   = 8'h80;
    localparam logic [2:0]  DSP_PRIO  = 3'd4;
    localparam logic [7:0]  DSP_VEC   = 8'h81;

    logic        clk;
    logic        rst;
    logic [15:0] memory_addr;
    logic        MemoryMappedIO_load;
    logic [15:0] MemoryMappedIO_out;
    logic        mmio_rd;
    logic [15:0] MemoryMappedIO_in;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;
    logic        IRQ;
    logic [2:0]  INTP;
    logic [7:0]  INTV;

    int n_tests = 0;
    int n_fail  = 0;

    lc3_mmio_console #(
        .KBD_DEPTH(KBD_DEPTH), .KBD_PRIO(KBD_PRIO), .KBD_VEC(KBD_VEC),
        .DSP_PRIO(DSP_PRIO), .DSP_VEC(DSP_VEC)
    ) dut (
        .clk(clk), .rst(rst), .memory_addr(memory_addr),
        .MemoryMappedIO_load(MemoryMappedIO_load), .MemoryMappedIO_out(MemoryMappedIO_out),
        .mmio_rd(mmio_rd), .MemoryMappedIO_in(MemoryMappedIO_in),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready),
        .IRQ(IRQ), .INTP(INTP), .INTV(INTV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_kie, m_die, m_drdy, m_dval, m_irq;
    logic [7:0] m_ddata;
    logic [2:0] m_intp;
    logic [7:0] m_intv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_kie   = 1'b0;
        m_die   = 1'b0;
        m_drdy  = 1'b1;
        m_dval  = 1'b0;
        m_ddata = 8'h00;
        m_irq   = 1'b0;
        m_intp  = 3'd0;
        m_intv  = 8'h00;
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        case (a)
            16'hFE00: return {(m_q.size() != 0), m_kie, 14'b0};
            16'hFE02: return (m_q.size() != 0) ? {8'h00, m_q[0]} : 16'h0000;
            16'hFE04: return {m_drdy, m_die, 14'b0};
            16'hFE06: return {8'h00, m_ddata};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic drive(input logic [15:0] a, input bit ld, input logic [15:0] wd,
                         input bit rd, input bit kv, input logic [7:0] kd);
        memory_addr         = a;
        MemoryMappedIO_load = ld;
        MemoryMappedIO_out  = wd;
        mmio_rd             = rd;
        kbd_valid           = kv;
        kbd_data            = kd;
    endtask

    // One clock: compare everything against the model, then advance the model.
    task automatic step();
        bit          ne, kreq, dreq, do_pop, do_push, wr_ddr, hs, ld;
        logic [15:0] a, wd;
        logic [7:0]  kd;
        @(negedge clk);
        chk("rdata", MemoryMappedIO_in, model_rd(memory_addr));
        chk("kbd_ready", kbd_ready, (m_q.size() < KBD_DEPTH));
        chk("dsp_valid", dsp_valid, m_dval);
        chk("dsp_data", dsp_data, m_ddata);
        chk("irq", IRQ, m_irq);
        chk("intp", INTP, m_intp);
        chk("intv", INTV, m_intv);
        a  = memory_addr;
        ld = MemoryMappedIO_load;
        wd = MemoryMappedIO_out;
        kd = kbd_data;
        ne      = (m_q.size() != 0);
        kreq    = ne && m_kie;
        dreq    = m_drdy && m_die;
        do_pop  = mmio_rd && (a == 16'hFE02) && ne;
        do_push = kbd_valid && (m_q.size() < KBD_DEPTH);
        wr_ddr  = ld && (a == 16'hFE06) && m_drdy;
        hs      = m_dval && dsp_ready;
        @(posedge clk);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(kd);
        if (ld && a == 16'hFE00) m_kie = wd[14];
        if (ld && a == 16'hFE04) m_die = wd[14];
        if (wr_ddr) begin
            m_ddata = wd[7:0];
            m_dval  = 1'b1;
            m_drdy  = 1'b0;
        end else if (hs) begin
            m_dval = 1'b0;
            m_drdy = 1'b1;
        end
        m_irq  = kreq || dreq;
        m_intp = kreq ? KBD_PRIO : (dreq ? DSP_PRIO : 3'd0);
        m_intv = kreq ? KBD_VEC  : (dreq ? DSP_VEC  : 8'h00);
        #1;
    endtask

    logic [15:0] addr_tbl [8] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06,
                                  16'hFE01, 16'hFF02, 16'hFE08, 16'hFFFE};

    initial begin
        rst = 1'b1;
        dsp_ready = 1'b0;
        drive(16'h0000, 0, 16'h0000, 0, 0, 8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        drive(16'hFE00, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("rst_kbsr", MemoryMappedIO_in, 16'h0000);
        chk("rst_kbd_ready", kbd_ready, 1'b1);
        chk("rst_irq", IRQ, 1'b0);
        step();
        drive(16'hFE04, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("rst_dsr", MemoryMappedIO_in, 16'h8000);
        step();
        drive(16'hFE06, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("rst_ddr", MemoryMappedIO_in, 16'h0000);
        step();

        // Fill to full, fifth push refused, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(16'hFE00, 0, 16'h0000, 0, 1, 8'h41 + 8'(i));
            step();
        end
        #1 chk("full_ready", kbd_ready, 1'b0);
        drive(16'hFE00, 0, 16'h0000, 0, 1, 8'h45);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(16'hFE02, 0, 16'h0000, 1, 0, 8'h00);
            #1 chk("kbdr_order", MemoryMappedIO_in, 16'h0041 + 16'(i));
            step();
        end
        drive(16'hFE00, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("kbsr_drained", MemoryMappedIO_in, 16'h0000);
        step();

        // Simultaneous push and pop
        drive(16'hFE00, 0, 16'h0000, 0, 1, 8'h10);
        step();
        drive(16'hFE00, 0, 16'h0000, 0, 1, 8'h11);
        step();
        drive(16'hFE02, 0, 16'h0000, 1, 1, 8'h55);
        #1 chk("pp_head0", MemoryMappedIO_in, 16'h0010);
        step();
        drive(16'hFE02, 0, 16'h0000, 1, 0, 8'h00);
        #1 chk("pp_head1", MemoryMappedIO_in, 16'h0011);
        step();
        drive(16'hFE02, 0, 16'h0000, 1, 0, 8'h00);
        #1 chk("pp_head2", MemoryMappedIO_in, 16'h0055);
        step();
        drive(16'hFE02, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("pp_empty", MemoryMappedIO_in, 16'h0000);
        step();

        // Keyboard interrupt latency
        drive(16'hFE00, 1, 16'h4000, 0, 0, 8'h00);
        step();
        drive(16'hFE00, 0, 16'h0000, 0, 1, 8'h30);
        step();
        drive(16'hFE00, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("kirq_not_yet", IRQ, 1'b0);
        step();
        #1 chk("kirq_irq", IRQ, 1'b1);
        chk("kirq_intp", INTP, 3'd4);
        chk("kirq_intv", INTV, 8'h80);
        drive(16'hFE02, 0, 16'h0000, 1, 0, 8'h00);
        #1 chk("kirq_data", MemoryMappedIO_in, 16'h0030);
        step();
        drive(16'hFE00, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("kirq_hold", IRQ, 1'b1);
        step();
        #1 chk("kirq_clear", IRQ, 1'b0);
        chk("kirq_clear_v", INTV, 8'h00);
        drive(16'hFE00, 1, 16'h0000, 0, 0, 8'h00);
        step();

        // Display write, dropped write, handshake
        drive(16'hFE06, 1, 16'h0048, 0, 0, 8'h00);
        step();
        drive(16'hFE04, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("ddr_valid", dsp_valid, 1'b1);
        chk("ddr_data", dsp_data, 8'h48);
        chk("ddr_dsr", MemoryMappedIO_in, 16'h0000);
        step();
        drive(16'hFE06, 1, 16'h0049, 0, 0, 8'h00);
        step();
        drive(16'hFE04, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("ddr_drop", dsp_data, 8'h48);
        dsp_ready = 1'b1;
        step();
        dsp_ready = 1'b0;
        #1 chk("hs_dsr", MemoryMappedIO_in, 16'h8000);
        chk("hs_valid", dsp_valid, 1'b0);
        chk("hs_data", dsp_data, 8'h48);
        step();

        // Arbitration, then reset mid-transfer
        drive(16'hFE00, 1, 16'h4000, 0, 0, 8'h00);
        step();
        drive(16'hFE04, 1, 16'h4000, 0, 0, 8'h00);
        step();
        drive(16'hFE00, 0, 16'h0000, 0, 1, 8'h60);
        step();
        drive(16'hFE00, 0, 16'h0000, 0, 1, 8'h61);
        step();
        drive(16'hFE00, 0, 16'h0000, 0, 0, 8'h00);
        step();
        #1 chk("arb_kbd_wins", INTV, 8'h80);
        for (int i = 0; i < 2; i++) begin
            drive(16'hFE02, 0, 16'h0000, 1, 0, 8'h00);
            step();
        end
        drive(16'hFE00, 0, 16'h0000, 0, 0, 8'h00);
        step();
        #1 chk("arb_dsp_v", INTV, 8'h81);
        chk("arb_dsp_irq", IRQ, 1'b1);
        drive(16'hFE00, 0, 16'h0000, 0, 1, 8'h70);
        step();
        drive(16'hFE06, 1, 16'h005A, 0, 0, 8'h00);
        step();
        drive(16'hFE00, 0, 16'h0000, 0, 0, 8'h00);
        #1 chk("pre_rst_valid", dsp_valid, 1'b1);
        #1 rst = 1'b1;
        #1 chk("arst_kbd_ready", kbd_ready, 1'b1);
        chk("arst_dsp_valid", dsp_valid, 1'b0);
        chk("arst_dsp_data", dsp_data, 8'h00);
        chk("arst_irq", IRQ, 1'b0);
        chk("arst_intp", INTP, 3'd0);
        chk("arst_intv", INTV, 8'h00);
        chk("arst_kbsr", MemoryMappedIO_in, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive(16'hFE04, 0, 16'h0000, 0, 0, 8'h00);
        step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] a;
            bit ld, rd;
            a  = addr_tbl[$urandom_range(0, 7)];
            ld = ($urandom_range(0, 3) == 0);
            rd = !ld && ($urandom_range(0, 2) == 0);
            dsp_ready = ($urandom_range(0, 2) == 0);
            drive(a, ld, 16'($urandom), rd, $urandom_range(0, 1) == 1, 8'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
